// File: rtl/fpu_op_track_pipe.sv
// rtl/fpu_op_track_pipe.sv - per-port op descriptor delay line with stall, flush, tag query and in-flight count
module fpu_op_track_pipe #(
   parameter int NPORT   = 3,
   parameter int DEPTH   = 3,
   parameter int OPW     = 21,
   parameter int TAGW    = 9,
   parameter int ADD_BIT = 10,
   parameter int CW      = $clog2(NPORT*DEPTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [NPORT-1:0]      iss_vld,
   input  logic [NPORT*OPW-1:0]  iss_op,
   input  logic [NPORT-1:0]      iss_xsub,
   input  logic [NPORT*TAGW-1:0] iss_tag,
   output logic [NPORT-1:0]      out_vld,
   output logic [NPORT*OPW-1:0]  out_op,
   output logic [NPORT-1:0]      out_xsub,
   output logic [NPORT*TAGW-1:0] out_tag,
   output logic [NPORT-1:0]      add_done,
   input  logic [TAGW-1:0]       qry_tag,
   output logic                  qry_hit,
   output logic [CW-1:0]         inflight
);

   // Index 0 is stage 1; index DEPTH-1 is the final stage driving out_*.
   logic [DEPTH-1:0][NPORT-1:0]      vld_q;
   logic [DEPTH-1:0][NPORT*OPW-1:0]  op_q;
   logic [DEPTH-1:0][NPORT-1:0]      xsub_q;
   logic [DEPTH-1:0][NPORT*TAGW-1:0] tag_q;
   logic [CW-1:0]                    cnt_q;
   logic [CW-1:0]                    iss_cnt;
   logic [CW-1:0]                    ret_cnt;
   logic                             advance;

   // Flush overrides stall: the line shifts so data fields keep moving, only valids die.
   assign advance = flush | ~stall;

   always_comb begin
      iss_cnt = '0;
      ret_cnt = '0;
      for (int p = 0; p < NPORT; p++) begin
         iss_cnt = iss_cnt + CW'(iss_vld[p]);
         ret_cnt = ret_cnt + CW'(vld_q[DEPTH-1][p]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q  <= '0;
         op_q   <= '0;
         xsub_q <= '0;
         tag_q  <= '0;
         cnt_q  <= '0;
      end else if (advance) begin
         vld_q[0]  <= flush ? '0 : iss_vld;
         op_q[0]   <= iss_op;
         xsub_q[0] <= iss_xsub;
         tag_q[0]  <= iss_tag;
         for (int s = 1; s < DEPTH; s++) begin
            vld_q[s]  <= flush ? '0 : vld_q[s-1];
            op_q[s]   <= op_q[s-1];
            xsub_q[s] <= xsub_q[s-1];
            tag_q[s]  <= tag_q[s-1];
         end
         cnt_q <= flush ? '0 : cnt_q + iss_cnt - ret_cnt;
      end
   end

   assign out_vld  = vld_q[DEPTH-1];
   assign out_op   = op_q[DEPTH-1];
   assign out_xsub = xsub_q[DEPTH-1];
   assign out_tag  = tag_q[DEPTH-1];
   assign inflight = cnt_q;

   always_comb begin
      add_done = '0;
      for (int p = 0; p < NPORT; p++) begin
         add_done[p] = out_vld[p] & out_op[p*OPW+ADD_BIT] & ~out_xsub[p];
      end
   end

   // Looks only at registered stages; an entry on the issue inputs is not yet in flight.
   always_comb begin
      qry_hit = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
         for (int p = 0; p < NPORT; p++) begin
            if (vld_q[s][p] && (tag_q[s][p*TAGW +: TAGW] == qry_tag)) begin
               qry_hit = 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_fpu_op_track_pipe.sv
// tb/tb_fpu_op_track_pipe.sv - self-checking bench for fpu_op_track_pipe at DEPTH 1, 3 and 8
module tb_fpu_op_track_pipe;

   localparam int NPORT = 3;
   localparam int OPW   = 21;
   localparam int TAGW  = 9;
   localparam int ADDB  = 10;
   localparam int CW1   = $clog2(NPORT*1+1);
   localparam int CW3   = $clog2(NPORT*3+1);
   localparam int CW8   = $clog2(NPORT*8+1);

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic                  stall = 1'b0;
   logic                  flush = 1'b0;
   logic [NPORT-1:0]      iss_vld = '0;
   logic [NPORT*OPW-1:0]  iss_op = '0;
   logic [NPORT-1:0]      iss_xsub = '0;
   logic [NPORT*TAGW-1:0] iss_tag = '0;
   logic [TAGW-1:0]       qry_tag = '0;

   logic [NPORT-1:0]      ov1, ox1, ad1, ov3, ox3, ad3, ov8, ox8, ad8;
   logic [NPORT*OPW-1:0]  oo1, oo3, oo8;
   logic [NPORT*TAGW-1:0] ot1, ot3, ot8;
   logic                  qh1, qh3, qh8;
   logic [CW1-1:0]        inf1;
   logic [CW3-1:0]        inf3;
   logic [CW8-1:0]        inf8;

   fpu_op_track_pipe #(.DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .iss_vld(iss_vld), .iss_op(iss_op),
      .iss_xsub(iss_xsub), .iss_tag(iss_tag), .out_vld(ov1), .out_op(oo1), .out_xsub(ox1),
      .out_tag(ot1), .add_done(ad1), .qry_tag(qry_tag), .qry_hit(qh1), .inflight(inf1));
   fpu_op_track_pipe #(.DEPTH(3)) u_d3 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .iss_vld(iss_vld), .iss_op(iss_op),
      .iss_xsub(iss_xsub), .iss_tag(iss_tag), .out_vld(ov3), .out_op(oo3), .out_xsub(ox3),
      .out_tag(ot3), .add_done(ad3), .qry_tag(qry_tag), .qry_hit(qh3), .inflight(inf3));
   fpu_op_track_pipe #(.DEPTH(8)) u_d8 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .iss_vld(iss_vld), .iss_op(iss_op),
      .iss_xsub(iss_xsub), .iss_tag(iss_tag), .out_vld(ov8), .out_op(oo8), .out_xsub(ox8),
      .out_tag(ot8), .add_done(ad8), .qry_tag(qry_tag), .qry_hit(qh8), .inflight(inf8));

   always #5 clk = ~clk;

   // Issuing while stalled (and not flushing) is an upstream protocol error.
   always @(posedge clk) begin
      if (!rst) assert (!(stall && !flush && (|iss_vld)))
         else $error("issue presented during stall");
   end

   typedef struct {
      logic [NPORT-1:0]      vld;
      logic [NPORT*OPW-1:0]  op;
      logic [NPORT-1:0]      xsub;
      logic [NPORT*TAGW-1:0] tag;
   } rec_t;

   // hist[k] is the batch that has advanced k+1 times, i.e. the content of stage k+1.
   rec_t hist[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_update();
      rec_t r;
      r.vld  = iss_vld;
      r.op   = iss_op;
      r.xsub = iss_xsub;
      r.tag  = iss_tag;
      if (flush) begin
         foreach (hist[i]) hist[i].vld = '0;
         r.vld = '0;
         hist.push_front(r);
      end else if (!stall) begin
         hist.push_front(r);
      end
      while (hist.size() > 8) void'(hist.pop_back());
   endtask

   task automatic check_one(int d, logic [NPORT-1:0] ov, logic [NPORT*OPW-1:0] oo,
                            logic [NPORT-1:0] ox, logic [NPORT*TAGW-1:0] ot,
                            logic [NPORT-1:0] ad, logic qh, logic [7:0] inf);
      rec_t             e;
      logic [NPORT-1:0] e_add;
      int               cnt;
      logic             hit;
      e = '{vld: '0, op: '0, xsub: '0, tag: '0};
      if (hist.size() >= d) e = hist[d-1];
      cnt = 0;
      hit = 1'b0;
      for (int i = 0; i < d && i < hist.size(); i++) begin
         for (int p = 0; p < NPORT; p++) begin
            if (hist[i].vld[p]) begin
               cnt++;
               if (hist[i].tag[p*TAGW +: TAGW] == qry_tag) hit = 1'b1;
            end
         end
      end
      for (int p = 0; p < NPORT; p++) e_add[p] = e.vld[p] && e.op[p*OPW+ADDB] && !e.xsub[p];
      chk($sformatf("d%0d out_vld", d), 64'(ov), 64'(e.vld));
      chk($sformatf("d%0d add_done", d), 64'(ad), 64'(e_add));
      chk($sformatf("d%0d inflight", d), 64'(inf), 64'(cnt));
      chk($sformatf("d%0d qry_hit", d), 64'(qh), 64'(hit));
      if (hist.size() < d) begin
         chk($sformatf("d%0d out_op idle", d), 64'(oo), 64'(0));
         chk($sformatf("d%0d out_xsub idle", d), 64'(ox), 64'(0));
         chk($sformatf("d%0d out_tag idle", d), 64'(ot), 64'(0));
      end
      for (int p = 0; p < NPORT; p++) begin
         if (e.vld[p]) begin
            chk($sformatf("d%0d p%0d op", d, p), 64'(oo[p*OPW +: OPW]), 64'(e.op[p*OPW +: OPW]));
            chk($sformatf("d%0d p%0d xsub", d, p), 64'(ox[p]), 64'(e.xsub[p]));
            chk($sformatf("d%0d p%0d tag", d, p), 64'(ot[p*TAGW +: TAGW]), 64'(e.tag[p*TAGW +: TAGW]));
         end
      end
   endtask

   task automatic check_all();
      check_one(1, ov1, oo1, ox1, ot1, ad1, qh1, 8'(inf1));
      check_one(3, ov3, oo3, ox3, ot3, ad3, qh3, 8'(inf3));
      check_one(8, ov8, oo8, ox8, ot8, ad8, qh8, 8'(inf8));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_all();
   endtask

   task automatic drive(logic s, logic f, logic [NPORT-1:0] v, logic x, logic [TAGW-1:0] t);
      stall = s;
      flush = f;
      iss_vld = v;
      iss_xsub = {NPORT{x}};
      for (int p = 0; p < NPORT; p++) begin
         iss_op[p*OPW +: OPW]   = OPW'(1 << ADDB);
         iss_tag[p*TAGW +: TAGW] = t;
      end
   endtask

   typedef struct {
      logic             s;
      logic             f;
      logic [NPORT-1:0] v;
      logic             x;
      logic [NPORT-1:0] e_vld;
      logic [NPORT-1:0] e_add;
      int               e_inf;
   } vec_t;

   vec_t vecs[23];

   initial begin
      vecs = '{
         '{0, 0, 3'b010, 0, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b010, 3'b010, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b010, 1, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b010, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b010, 0, 3'b000, 3'b000, 1},
         '{1, 0, 3'b000, 0, 3'b000, 3'b000, 1},
         '{1, 0, 3'b000, 0, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 1},
         '{0, 0, 3'b000, 0, 3'b010, 3'b010, 1},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b111, 0, 3'b000, 3'b000, 3},
         '{0, 0, 3'b111, 0, 3'b000, 3'b000, 6},
         '{0, 1, 3'b111, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b001, 0, 3'b000, 3'b000, 1},
         '{1, 1, 3'b000, 0, 3'b000, 3'b000, 0},
         '{0, 0, 3'b000, 0, 3'b000, 3'b000, 0}
      };

      // Reset state, with a query tag that matches the zeroed tag fields.
      qry_tag = '0;
      @(negedge clk);
      @(negedge clk);
      check_all();
      rst = 1'b0;
      check_all();

      // Directed latency / xsub / stall / flush table, expectations for DEPTH=3.
      foreach (vecs[i]) begin
         drive(vecs[i].s, vecs[i].f, vecs[i].v, vecs[i].x, 9'h005);
         step();
         chk($sformatf("vec%0d out_vld", i), 64'(ov3), 64'(vecs[i].e_vld));
         chk($sformatf("vec%0d add_done", i), 64'(ad3), 64'(vecs[i].e_add));
         chk($sformatf("vec%0d inflight", i), 64'(inf3), 64'(vecs[i].e_inf));
      end

      // Tag query on DEPTH=3.
      qry_tag = 9'h01A;
      drive(0, 0, 3'b001, 0, 9'h000);
      iss_tag[0 +: TAGW] = 9'h01A;
      chk("qry issue only", 64'(qh3), 64'(0));
      step();
      drive(0, 0, 3'b000, 0, 9'h000);
      step();
      chk("qry stage2", 64'(qh3), 64'(1));
      step();
      step();
      chk("qry retired", 64'(qh3), 64'(0));
      drive(0, 0, 3'b001, 0, 9'h01A);
      #1;
      chk("qry issue only after retire", 64'(qh3), 64'(0));
      step();

      // Saturation: every port issues every cycle.
      qry_tag = 9'h005;
      drive(0, 0, 3'b111, 0, 9'h005);
      for (int c = 0; c < 10; c++) begin
         step();
         if (c >= 8) begin
            chk("sat d1", 64'(inf1), 64'(3));
            chk("sat d3", 64'(inf3), 64'(9));
            chk("sat d8", 64'(inf8), 64'(24));
         end
      end

      // Reset between edges with the pipe full.
      #2 rst = 1'b1;
      #1;
      chk("rst d1 out_vld", 64'(ov1), 64'(0));
      chk("rst d3 out_vld", 64'(ov3), 64'(0));
      chk("rst d8 out_vld", 64'(ov8), 64'(0));
      chk("rst d3 inflight", 64'(inf3), 64'(0));
      chk("rst d8 inflight", 64'(inf8), 64'(0));
      chk("rst d8 qry_hit", 64'(qh8), 64'(0));
      hist.delete();
      drive(0, 0, 3'b000, 0, 9'h000);
      @(negedge clk);
      rst = 1'b0;
      check_all();
      drive(0, 0, 3'b100, 0, 9'h011);
      step();
      drive(0, 0, 3'b000, 0, 9'h000);
      for (int c = 0; c < 3; c++) step();
      chk("post-rst first out d3", 64'(ov3), 64'(0));

      // Random issue / stall / flush mix.
      for (int c = 0; c < 10000; c++) begin
         stall = ($urandom_range(0, 4) == 0);
         flush = ($urandom_range(0, 22) == 0);
         iss_vld = (stall && !flush) ? '0 : NPORT'($urandom());
         iss_op = (NPORT*OPW)'({$urandom(), $urandom()});
         iss_xsub = NPORT'($urandom());
         for (int p = 0; p < NPORT; p++) iss_tag[p*TAGW +: TAGW] = TAGW'($urandom_range(0, 7));
         qry_tag = TAGW'($urandom_range(0, 7));
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
